cpu_param: RTL and testbench

- Parametrised second-generation accumulator CPU for the microsys memory bus. Widens data and address through parameters and makes memory wait states configurable.
- Extends the ISA from 4 to 8 opcodes: adds LDA, JMP, ADC and HLT, keeps a separate carry flag, and gains a halt state.
- Single-port synchronous memory interface: registered addr, rw and data_out, with data_in sampled a fixed number of cycles after addr changes.

---
 rtl/cpu_param.sv | 174 +++++++++++++++++
 tb/tb_cpu_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_param.sv
// cpu_param: parametrised accumulator CPU (8 opcodes, carry flag, halt state) for the
// microsys bus; data_in is sampled WAIT_STATES+1 edges after each addr update.
module cpu_param #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 5,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0] addr,
   output logic              rw,
   output logic              halted,
   output logic              carry
);

   generate
      if (ADDR_W > DATA_W - 3) begin : g_bad_addr_w
         $error("cpu_param: ADDR_W must not exceed DATA_W-3");
      end
      if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
         $error("cpu_param: WAIT_STATES must be in 0..15");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_RESET, S_FETCH, S_DECODE, S_OPWAIT, S_EXEC, S_STWAIT, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      OP_NOR = 3'b000, OP_ADD = 3'b001, OP_STA = 3'b010, OP_JCC = 3'b011,
      OP_LDA = 3'b100, OP_JMP = 3'b101, OP_ADC = 3'b110, OP_HLT = 3'b111
   } opcode_t;

   // With no wait states the wait sub-states are skipped entirely, so the sampling
   // state is entered straight from the edge that drives addr.
   localparam logic [3:0] WAIT_FULL   = 4'(WAIT_STATES);
   localparam logic [3:0] WAIT_LAST   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam state_t     FETCH_ENTRY = (WAIT_STATES == 0) ? S_DECODE : S_FETCH;
   localparam state_t     OP_ENTRY    = (WAIT_STATES == 0) ? S_EXEC : S_OPWAIT;

   state_t            state, state_n;
   opcode_t           op_q, op_n;
   logic [ADDR_W-1:0] pc, pc_n, addr_n, pc_inc, target;
   logic [DATA_W-1:0] acc, acc_n, data_out_n;
   logic [3:0]        cnt, cnt_n;
   logic              carry_n, rw_n, halted_n;
   opcode_t           opcode;

   assign opcode = opcode_t'(data_in[DATA_W-1 -: 3]);
   assign target = data_in[ADDR_W-1:0];
   assign pc_inc = pc + ADDR_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_RESET;
         op_q     <= OP_NOR;
         pc       <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         addr     <= '0;
         rw       <= 1'b1;
         data_out <= '0;
         halted   <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_n;
         op_q     <= op_n;
         pc       <= pc_n;
         acc      <= acc_n;
         carry    <= carry_n;
         addr     <= addr_n;
         rw       <= rw_n;
         data_out <= data_out_n;
         halted   <= halted_n;
         cnt      <= cnt_n;
      end
   end

   // STWAIT loads the full wait count because its completing edge is an extra cycle of
   // rw low, mirroring the EXEC edge of the read path.
   always_comb begin
      state_n    = state;
      op_n       = op_q;
      pc_n       = pc;
      acc_n      = acc;
      carry_n    = carry;
      addr_n     = addr;
      rw_n       = rw;
      data_out_n = data_out;
      halted_n   = halted;
      cnt_n      = cnt;
      case (state)
         S_RESET: begin
            addr_n  = pc;
            cnt_n   = WAIT_LAST;
            state_n = FETCH_ENTRY;
         end
         S_FETCH: begin
            if (cnt == 4'd0) state_n = S_DECODE;
            else             cnt_n   = cnt - 4'd1;
         end
         S_DECODE: begin
            op_n  = opcode;
            cnt_n = WAIT_LAST;
            case (opcode)
               OP_NOR, OP_ADD, OP_ADC, OP_LDA: begin
                  addr_n  = target;
                  state_n = OP_ENTRY;
               end
               OP_STA: begin
                  addr_n     = target;
                  rw_n       = 1'b0;
                  data_out_n = acc;
                  cnt_n      = WAIT_FULL;
                  state_n    = S_STWAIT;
               end
               OP_JMP: begin
                  pc_n    = target;
                  addr_n  = target;
                  state_n = FETCH_ENTRY;
               end
               OP_JCC: begin
                  if (carry) begin
                     carry_n = 1'b0;
                     pc_n    = pc_inc;
                     addr_n  = pc_inc;
                  end else begin
                     pc_n    = target;
                     addr_n  = target;
                  end
                  state_n = FETCH_ENTRY;
               end
               OP_HLT: begin
                  halted_n = 1'b1;
                  state_n  = S_HALT;
               end
            endcase
         end
         S_OPWAIT: begin
            if (cnt == 4'd0) state_n = S_EXEC;
            else             cnt_n   = cnt - 4'd1;
         end
         S_EXEC: begin
            case (op_q)
               OP_NOR:  acc_n = ~(acc | data_in);
               OP_ADD:  {carry_n, acc_n} = {1'b0, acc} + {1'b0, data_in};
               OP_ADC:  {carry_n, acc_n} = {1'b0, acc} + {1'b0, data_in} + {{DATA_W{1'b0}}, carry};
               OP_LDA:  acc_n = data_in;
               default: ;
            endcase
            pc_n    = pc_inc;
            addr_n  = pc_inc;
            cnt_n   = WAIT_LAST;
            state_n = FETCH_ENTRY;
         end
         S_STWAIT: begin
            if (cnt == 4'd0) begin
               rw_n    = 1'b1;
               pc_n    = pc_inc;
               addr_n  = pc_inc;
               cnt_n   = WAIT_LAST;
               state_n = FETCH_ENTRY;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         S_HALT: ;
         default: state_n = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: a WAIT_STATES=1 instance fed by a wait-aware memory
// model, and a WAIT_STATES=3 instance whose data_in is driven cycle by cycle.
module tb_cpu_param;

   logic       clk = 1'b0;
   logic       reset, reset3;
   logic [7:0] data_in, data_out, data_in3, data_out3;
   logic [4:0] addr, addr3;
   logic       rw, rw3, halted, halted3, carry, carry3;

   int num_checks = 0;
   int num_errors = 0;
   int edge_num   = 0;

   logic [7:0] mem [32];
   int         age       = 0;
   logic [4:0] last_addr = '0;
   bit         rand_mode = 1'b0;

   always #5 clk = ~clk;

   cpu_param #(.DATA_W(8), .ADDR_W(5), .WAIT_STATES(1)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out),
      .addr(addr), .rw(rw), .halted(halted), .carry(carry)
   );

   cpu_param #(.DATA_W(8), .ADDR_W(5), .WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(reset3), .data_in(data_in3), .data_out(data_out3),
      .addr(addr3), .rw(rw3), .halted(halted3), .carry(carry3)
   );

   // Memory returns garbage until addr has been stable for one full cycle, so an early
   // sample by the WAIT_STATES=1 instance picks up a wrong value.
   always @(negedge clk) begin
      if (rw == 1'b0) mem[addr] = data_out;
      if (addr != last_addr) begin
         age       = 0;
         last_addr = addr;
      end else if (age < 1000) begin
         age = age + 1;
      end
      if (rand_mode || age < 1) data_in = 8'($urandom);
      else                      data_in = mem[addr];
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      num_checks++;
      assert (observed === expected) else begin
         num_errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      edge_num++;
   endtask

   task automatic advance_to(input int e);
      while (edge_num < e) tick();
   endtask

   initial begin
      reset    = 1'b1;
      reset3   = 1'b1;
      data_in3 = 8'h00;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      mem[0]  = 8'h90;  mem[1]  = 8'h31;  mem[2]  = 8'h52;  mem[3]  = 8'h65;
      mem[4]  = 8'hA3;  mem[5]  = 8'h95;  mem[6]  = 8'h35;  mem[7]  = 8'h95;
      mem[8]  = 8'hD4;  mem[9]  = 8'h18;  mem[10] = 8'h59;  mem[11] = 8'hBF;
      mem[16] = 8'hF0;  mem[17] = 8'h20;  mem[20] = 8'h00;  mem[21] = 8'hFF;
      mem[24] = 8'h0F;  mem[31] = 8'h90;

      @(negedge clk);
      $display("[TB] reset values");
      check_output("rst_addr",   addr,   0);
      check_output("rst_rw",     rw,     1);
      check_output("rst_halted", halted, 0);
      check_output("rst_carry",  carry,  0);

      // First instruction is sampled two edges after the RESET edge.
      reset    = 1'b0;
      edge_num = -1;
      advance_to(1);
      check_output("fetch_addr_e1", addr, 0);
      advance_to(2);
      check_output("first_sample_e2", addr, 16);
      advance_to(4);
      check_output("lda_next_fetch", addr, 1);

      $display("[TB] asynchronous reset in FETCH");
      #2 reset = 1'b1;
      #1;
      check_output("async_rst_addr", addr, 0);
      check_output("async_rst_rw",   rw,   1);
      tick();
      reset    = 1'b0;
      edge_num = -1;

      $display("[TB] load/add/store");
      advance_to(0);
      check_output("e0_addr", addr, 0);
      advance_to(8);
      check_output("add_next_addr", addr, 2);
      check_output("add_carry",     carry, 1);
      advance_to(10);
      check_output("sta_addr",     addr,     18);
      check_output("sta_rw_low_1", rw,       0);
      check_output("sta_data",     data_out, 8'h10);
      advance_to(11);
      check_output("sta_rw_low_2", rw, 0);
      advance_to(12);
      check_output("sta_done_rw",   rw,       1);
      check_output("sta_done_addr", addr,     3);
      check_output("sta_data_hold", data_out, 8'h10);
      mem[0] = 8'hE0;

      $display("[TB] JCC");
      advance_to(13);
      check_output("jcc_c1_wait", addr, 3);
      advance_to(14);
      check_output("jcc_c1_addr",  addr,  4);
      check_output("jcc_c1_carry", carry, 0);
      advance_to(16);
      check_output("jmp_back", addr, 3);
      advance_to(18);
      check_output("jcc_c0_addr", addr, 5);

      $display("[TB] ADC/NOR");
      advance_to(26);
      check_output("add_ff_carry", carry, 1);
      advance_to(34);
      check_output("adc_addr",  addr,  9);
      check_output("adc_carry", carry, 1);
      advance_to(38);
      check_output("nor_carry", carry, 1);
      advance_to(40);
      check_output("sta2_addr", addr,     25);
      check_output("sta2_rw",   rw,       0);
      check_output("nor_acc",   data_out, 8'hF0);
      advance_to(42);
      check_output("sta2_next", addr, 11);

      $display("[TB] wrap and halt");
      advance_to(44);
      check_output("jmp31_addr", addr, 31);
      advance_to(48);
      check_output("pc_wrap_addr", addr, 0);
      advance_to(49);
      check_output("hlt_not_yet", halted, 0);
      advance_to(50);
      check_output("halted",      halted, 1);
      check_output("halt_addr",   addr,   0);
      rand_mode = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check_output("halt_hold_addr", addr, 0);
      end
      check_output("halt_hold_halted", halted,   1);
      check_output("halt_hold_rw",     rw,       1);
      check_output("halt_hold_carry",  carry,    1);
      check_output("halt_hold_data",   data_out, 8'hF0);
      #2 reset = 1'b1;
      #1;
      check_output("halt_rst_halted", halted,   0);
      check_output("halt_rst_carry",  carry,    0);
      check_output("halt_rst_data",   data_out, 0);

      $display("[TB] WAIT_STATES=3 instance");
      @(negedge clk);
      reset3   = 1'b0;
      data_in3 = 8'hBF;
      edge_num = -1;
      advance_to(0);
      check_output("w3_e0_addr", addr3, 0);
      advance_to(3);
      check_output("w3_ignore_early", addr3, 0);
      data_in3 = 8'h90;
      advance_to(4);
      check_output("w3_lda_target", addr3, 16);
      data_in3 = 8'h00;
      advance_to(7);
      check_output("w3_opwait_hold", addr3, 16);
      data_in3 = 8'h3C;
      advance_to(8);
      check_output("w3_lda_8cycles", addr3, 1);
      data_in3 = 8'hBF;
      advance_to(11);
      data_in3 = 8'h4A;
      advance_to(12);
      check_output("w3_sta_addr", addr3,     10);
      check_output("w3_sta_data", data_out3, 8'h3C);
      check_output("w3_rw_low_1", rw3,       0);
      data_in3 = 8'hBF;
      advance_to(15);
      check_output("w3_rw_low_4", rw3, 0);
      advance_to(16);
      check_output("w3_sta_done_rw",   rw3,   1);
      check_output("w3_sta_done_addr", addr3, 2);
      advance_to(19);
      data_in3 = 8'h4B;
      advance_to(20);
      check_output("w3_sta2_rw", rw3, 0);

      $display("[TB] reset during STA");
      #2 reset3 = 1'b1;
      #1;
      check_output("w3_rst_rw",   rw3,       1);
      check_output("w3_rst_addr", addr3,     0);
      check_output("w3_rst_data", data_out3, 0);

      $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
      $finish;
   end

endmodule
